// File: rtl/vga_clock_frontend.sv
// VGA digital clock front end: 640x400@70Hz sync and coordinates, font block mapping,
// palette colour, and auto-repeating adjust buttons paced by the frame tick.
module vga_button_repeat #(
  parameter int MAX_COUNT = 16,
  parameter int DEC_COUNT = 1,
  parameter int MIN_COUNT = 2
) (
  input  logic px_clk,
  input  logic reset,
  input  logic frame_en,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(MAX_COUNT + 1);

  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [CW-1:0] interval, interval_nx, interval_dec;
  logic          sync1, sync2, prev, prev_nx, pulse_nx;

  // Synchroniser runs through reset so the first post-reset sample sees the real button.
  always_ff @(posedge px_clk) begin
    sync1 <= btn;
    sync2 <= sync1;
  end

  // prev resets high: a button held through reset must be sampled low before it pulses.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      interval <= CW'(MAX_COUNT);
      prev     <= 1'b1;
      pulse    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      interval <= interval_nx;
      prev     <= prev_nx;
      pulse    <= pulse_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    interval_nx  = interval;
    prev_nx      = prev;
    pulse_nx     = 1'b0;
    cnt_inc      = cnt + CW'(1);
    interval_dec = (int'(interval) - DEC_COUNT >= MIN_COUNT) ?
                   interval - CW'(DEC_COUNT) : CW'(MIN_COUNT);
    if (frame_en) begin
      prev_nx = sync2;
      case (state)
        ST_IDLE: begin
          if (sync2 && !prev) begin
            pulse_nx    = 1'b1;
            cnt_nx      = '0;
            interval_nx = CW'(MAX_COUNT);
            state_nx    = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!sync2) begin
            interval_nx = CW'(MAX_COUNT);
            state_nx    = ST_IDLE;
          end else if (cnt_inc == interval) begin
            pulse_nx    = 1'b1;
            cnt_nx      = '0;
            interval_nx = interval_dec;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end
endmodule

module vga_clock_frontend #(
  parameter int FONT_W    = 4,
  parameter int FONT_H    = 5,
  parameter int X_OFFSET  = 64,
  parameter int Y_OFFSET  = 200,
  parameter int MAX_COUNT = 16,
  parameter int DEC_COUNT = 1,
  parameter int MIN_COUNT = 2,
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 449
) (
  input  logic                       px_clk,
  input  logic                       reset,
  input  logic                       adj_hrs,
  input  logic                       adj_min,
  input  logic                       adj_sec,
  input  logic [3:0]                 number,
  input  logic [3:0]                 color_offset,
  output logic                       hsync,
  output logic                       vsync,
  output logic [9:0]                 x_px,
  output logic [9:0]                 y_px,
  output logic                       activevideo,
  output logic [5:0]                 x_block,
  output logic [5:0]                 y_block,
  output logic                       adj_hrs_pulse,
  output logic                       adj_min_pulse,
  output logic                       adj_sec_pulse,
  output logic [5:0]                 digit_index,
  output logic [$clog2(FONT_W)-1:0]  col_index,
  output logic [5:0]                 color
);
  localparam int         CIW    = $clog2(FONT_W);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic       frame_en;
  logic [9:0] x_rel, y_rel;
  logic [3:0] code, pal_idx;
  logic [5:0] pal_color;

  always_ff @(posedge px_clk) begin
    if (reset) begin
      x_px <= '0;
      y_px <= '0;
    end else if (x_px == H_LAST) begin
      x_px <= '0;
      y_px <= (y_px == V_LAST) ? '0 : y_px + 10'd1;
    end else begin
      x_px <= x_px + 10'd1;
    end
  end

  always_comb begin
    activevideo = (x_px < 10'd640) && (y_px < 10'd400);
    hsync       = !((x_px >= 10'd656) && (x_px <= 10'd751));
    vsync       = (y_px >= 10'd412) && (y_px <= 10'd413);
    frame_en    = (x_px == 10'd0) && (y_px == 10'd0);
    x_rel       = x_px - 10'(X_OFFSET);
    y_rel       = y_px - 10'(Y_OFFSET);
    x_block     = x_rel[9:4];
    y_block     = y_rel[9:4];
    code        = (number > 4'd11) ? 4'd11 : number;
    digit_index = 6'(int'(code) * FONT_H);
    col_index   = CIW'(int'(x_block) % FONT_W);
    pal_idx     = 4'(int'(x_block) / FONT_W) + color_offset;
    case (pal_idx)
      4'd0:    pal_color = 6'h30;
      4'd1:    pal_color = 6'h34;
      4'd2:    pal_color = 6'h38;
      4'd3:    pal_color = 6'h3C;
      4'd4:    pal_color = 6'h2C;
      4'd5:    pal_color = 6'h1C;
      4'd6:    pal_color = 6'h0C;
      4'd7:    pal_color = 6'h0D;
      4'd8:    pal_color = 6'h0E;
      4'd9:    pal_color = 6'h0F;
      4'd10:   pal_color = 6'h0B;
      4'd11:   pal_color = 6'h07;
      4'd12:   pal_color = 6'h03;
      4'd13:   pal_color = 6'h13;
      4'd14:   pal_color = 6'h23;
      default: pal_color = 6'h33;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (reset) color <= '0;
    else       color <= pal_color;
  end

  vga_button_repeat #(.MAX_COUNT(MAX_COUNT), .DEC_COUNT(DEC_COUNT), .MIN_COUNT(MIN_COUNT))
    u_btn_hrs (.px_clk(px_clk), .reset(reset), .frame_en(frame_en), .btn(adj_hrs), .pulse(adj_hrs_pulse));
  vga_button_repeat #(.MAX_COUNT(MAX_COUNT), .DEC_COUNT(DEC_COUNT), .MIN_COUNT(MIN_COUNT))
    u_btn_min (.px_clk(px_clk), .reset(reset), .frame_en(frame_en), .btn(adj_min), .pulse(adj_min_pulse));
  vga_button_repeat #(.MAX_COUNT(MAX_COUNT), .DEC_COUNT(DEC_COUNT), .MIN_COUNT(MIN_COUNT))
    u_btn_sec (.px_clk(px_clk), .reset(reset), .frame_en(frame_en), .btn(adj_sec), .pulse(adj_sec_pulse));
endmodule

// File: tb/tb_vga_clock_frontend.sv
// Bench for vga_clock_frontend: full-size timing instance, a tall narrow instance for vertical
// timing, and a tiny-frame instance so button repeat sequences fit in a short run.
module tb_vga_clock_frontend;
  localparam int HA = 800, VA = 449, FA = HA * VA;
  localparam int HB = 4,   VB = 449, FB = HB * VB;
  localparam int HC = 8,   VC = 4,   FC = HC * VC;
  localparam int MAXC = 16, DECC = 1, MINC = 2;

  logic       px_clk = 1'b0;
  logic       reset = 1'b1;
  logic       adj_hrs = 1'b0, adj_min = 1'b0, adj_sec = 1'b0;
  logic [3:0] number = 4'd0, color_offset = 4'd0;

  logic a_hs, a_vs, a_av, a_ph, a_pm, a_ps;
  logic [9:0] a_x, a_y;
  logic [5:0] a_xb, a_yb, a_di, a_col;
  logic [1:0] a_ci;
  logic b_hs, b_vs, b_av, b_ph, b_pm, b_ps;
  logic [9:0] b_x, b_y;
  logic [5:0] b_xb, b_yb, b_di, b_col;
  logic [1:0] b_ci;
  logic c_hs, c_vs, c_av, c_ph, c_pm, c_ps;
  logic [9:0] c_x, c_y;
  logic [5:0] c_xb, c_yb, c_di, c_col;
  logic [1:0] c_ci;

  vga_clock_frontend u_a (
    .px_clk(px_clk), .reset(reset), .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
    .number(number), .color_offset(color_offset), .hsync(a_hs), .vsync(a_vs), .x_px(a_x),
    .y_px(a_y), .activevideo(a_av), .x_block(a_xb), .y_block(a_yb), .adj_hrs_pulse(a_ph),
    .adj_min_pulse(a_pm), .adj_sec_pulse(a_ps), .digit_index(a_di), .col_index(a_ci), .color(a_col));

  vga_clock_frontend #(.H_TOTAL(HB), .V_TOTAL(VB)) u_b (
    .px_clk(px_clk), .reset(reset), .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
    .number(number), .color_offset(color_offset), .hsync(b_hs), .vsync(b_vs), .x_px(b_x),
    .y_px(b_y), .activevideo(b_av), .x_block(b_xb), .y_block(b_yb), .adj_hrs_pulse(b_ph),
    .adj_min_pulse(b_pm), .adj_sec_pulse(b_ps), .digit_index(b_di), .col_index(b_ci), .color(b_col));

  vga_clock_frontend #(.H_TOTAL(HC), .V_TOTAL(VC)) u_c (
    .px_clk(px_clk), .reset(reset), .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
    .number(number), .color_offset(color_offset), .hsync(c_hs), .vsync(c_vs), .x_px(c_x),
    .y_px(c_y), .activevideo(c_av), .x_block(c_xb), .y_block(c_yb), .adj_hrs_pulse(c_ph),
    .adj_min_pulse(c_pm), .adj_sec_pulse(c_ps), .digit_index(c_di), .col_index(c_ci), .color(c_col));

  always #20 px_clk = ~px_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_low = 0, vs_high = 0, max_ax = 0, b_org0 = -1, b_org1 = -1, pm_count = 0;
  logic [5:0] pal [16] = '{6'h30, 6'h34, 6'h38, 6'h3C, 6'h2C, 6'h1C, 6'h0C, 6'h0D,
                           6'h0E, 6'h0F, 6'h0B, 6'h07, 6'h03, 6'h13, 6'h23, 6'h33};
  int run [3];
  bit armed [3];
  bit lvl [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int blk(input int v, input int off);
    return ((v - off + 1024) % 1024) / 16;
  endfunction

  // True when a hold that is n frames old lands on a repeat: 0, 16, 31, 45, ... with gap floor 2.
  function automatic bit is_pulse_at(input int n);
    int t = 0;
    int iv = MAXC;
    while (t < n) begin
      t += iv;
      iv = (iv - DECC < MINC) ? MINC : iv - DECC;
    end
    return t == n;
  endfunction

  task automatic model_frame(output bit [2:0] ep);
    ep = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (!lvl[i]) begin
        run[i] = -1;
        armed[i] = 1'b1;
      end else if (run[i] >= 0) begin
        run[i]++;
        ep[i] = is_pulse_at(run[i]);
      end else if (armed[i]) begin
        run[i] = 0;
        armed[i] = 1'b0;
        ep[i] = 1'b1;
      end
    end
  endtask

  task automatic tick(input bit ab);
    int xb0, p, x, y;
    logic [3:0] off0;
    bit [2:0] ep;
    xb0 = blk((cyc % FA) % HA, 64);
    off0 = color_offset;
    @(posedge px_clk);
    #1;
    ep = 3'b000;
    if (cyc % FC == 0) model_frame(ep);
    chk("hrs_pulse", c_ph, ep[0]);
    chk("min_pulse", c_pm, ep[1]);
    chk("sec_pulse", c_ps, ep[2]);
    if (c_pm) pm_count++;
    p = (cyc + 1) % FC;
    chk("c_x_px", c_x, p % HC);
    chk("c_y_px", c_y, p / HC);
    x = 0;
    y = 0;
    if (ab) begin
      p = (cyc + 1) % FA;
      x = p % HA;
      y = p / HA;
      chk("a_x_px", a_x, x);
      chk("a_y_px", a_y, y);
      chk("a_hsync", a_hs, !(x >= 656 && x <= 751));
      chk("a_activevideo", a_av, (x < 640) && (y < 400));
      chk("a_x_block", a_xb, blk(x, 64));
      chk("a_col_index", a_ci, blk(x, 64) % 4);
      chk("a_color", a_col, pal[((xb0 / 4) + off0) & 15]);
      if (xb0 == 13 && off0 == 4'd2) chk("color_xb13_off2", a_col, 6'h1C);
      if (xb0 == 13 && off0 == 4'd15) chk("color_xb13_off15", a_col, 6'h38);
      if (x == 64 || x == 79) chk("x_block_edge0", a_xb, 0);
      if (x == 272) begin
        chk("x_block_272", a_xb, 13);
        chk("col_index_272", a_ci, 1);
      end
      if (cyc < HA && !a_hs) hs_low++;
      if (int'(a_x) > max_ax) max_ax = int'(a_x);
      p = (cyc + 1) % FB;
      chk("b_x_px", b_x, p % HB);
      chk("b_y_px", b_y, p / HB);
      chk("b_vsync", b_vs, (p / HB == 412) || (p / HB == 413));
      chk("b_y_block", b_yb, blk(p / HB, 200));
      if (p / HB == 216) chk("y_block_216", b_yb, 1);
      if (cyc < FB && b_vs) vs_high++;
      if (b_x == 0 && b_y == 0) begin
        if (b_org0 < 0) b_org0 = cyc;
        else if (b_org1 < 0) b_org1 = cyc;
      end
    end
    number = 4'($urandom_range(0, 15));
    color_offset = 4'($urandom);
    if (ab && x == 272) color_offset = (y == 0) ? 4'd2 : 4'd15;
    if (ab && x == 100) number = 4'd3;
    if (ab && x == 101) number = 4'd10;
    if (ab && x == 102) number = 4'd15;
    #1;
    chk("digit_index", a_di, ((number > 4'd11) ? 11 : int'(number)) * 5);
    chk("c_digit_index", c_di, ((number > 4'd11) ? 11 : int'(number)) * 5);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge px_clk);
    #1;
    chk("rst_c_x", c_x, 0);
    chk("rst_c_y", c_y, 0);
    chk("rst_a_x", a_x, 0);
    chk("rst_a_color", a_col, 0);
    chk("rst_pulses", {c_ph, c_pm, c_ps}, 0);
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      run[i] = -1;
      armed[i] = 1'b0;
    end
  endtask

  task automatic set_btn(input logic [2:0] mask);
    while (cyc % FC != 16) tick(1'b0);
    adj_hrs = mask[0];
    adj_min = mask[1];
    adj_sec = mask[2];
    for (int i = 0; i < 3; i++) lvl[i] = mask[i];
  endtask

  task automatic frames(input int n);
    repeat (n * FC) tick(1'b0);
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) lvl[i] = 1'b0;
    do_reset();

    repeat (3700) tick(1'b1);
    chk("hsync_low_px", hs_low, 96);
    chk("vsync_high_cycles", vs_high, 2 * HB);
    chk("x_px_max", max_ax, 799);
    chk("frame_cycles", b_org1 - b_org0, FB);

    set_btn(3'b000);
    frames(2);
    pm_count = 0;
    set_btn(3'b010);
    frames(150);
    chk("min_hold_pulses", pm_count, 23);
    set_btn(3'b000);
    frames(2);
    pm_count = 0;
    set_btn(3'b010);
    frames(20);
    chk("min_repress_pulses", pm_count, 2);
    set_btn(3'b000);
    frames(2);

    for (int k = 0; k < 12; k++) begin
      set_btn(3'($urandom_range(1, 7)));
      frames($urandom_range(1, 40));
      set_btn(3'($urandom_range(0, 7)));
      frames($urandom_range(1, 5));
    end
    set_btn(3'b000);
    frames(2);

    set_btn(3'b111);
    frames(20);
    do_reset();
    pm_count = 0;
    frames(20);
    chk("held_after_reset", pm_count, 0);
    set_btn(3'b000);
    frames(2);
    set_btn(3'b111);
    frames(3);
    set_btn(3'b000);
    frames(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
